// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, counts retired instructions and halts on illegal opcodes.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_update,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic [1:0]       imm_src,
   output logic [1:0]       alu_op,
   output logic             halt,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire_s;
   logic             br_legal_s;
   logic             mem_req_s, mem_write_s, ir_write_s, pc_update_s, reg_write_s;

   // State and retired-instruction counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Next-state decode and retirement detection
   always_comb begin
      state_d    = state_q;
      retire_s   = 1'b0;
      br_legal_s = (funct3 == 3'b000) || (funct3 == 3'b001);
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BR:        state_d = br_legal_s ? S_BRANCH : S_ILLEGAL;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   if (op == OP_LW) state_d = S_MEMREAD; else state_d = S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB; else state_d = S_MEMREAD;
         S_MEMWB: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_d  = S_FETCH;
               retire_s = 1'b1;
            end else begin
               state_d  = S_MEMWRITE;
            end
         end
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB, S_BRANCH: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
         end
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_ILLEGAL;
      endcase
      if (retire_s) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else          instret_d = instret_q;
   end

   // Moore output decode; FETCH and BRANCH additionally look at mem_ready / zero
   always_comb begin
      mem_req_s   = 1'b0;
      mem_write_s = 1'b0;
      adr_src     = 1'b0;
      ir_write_s  = 1'b0;
      pc_update_s = 1'b0;
      reg_write_s = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_op      = 2'b00;
      halt        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_s   = 1'b1;
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            ir_write_s  = mem_ready;
            pc_update_s = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            mem_req_s = 1'b1;
            adr_src   = 1'b1;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_s = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            adr_src     = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            pc_update_s = 1'b1;
         end
         S_ALUWB:    reg_write_s = 1'b1;
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_op      = 2'b01;
            pc_update_s = zero ^ funct3[0];
         end
         S_ILLEGAL:  halt = 1'b1;
         default:    halt = 1'b1;
      endcase
   end

   // Immediate format follows the opcode directly so decode can use it immediately
   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BR:   imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Enables are held off for as long as reset is asserted
   assign mem_req   = mem_req_s   & rst_n;
   assign mem_write = mem_write_s & rst_n;
   assign ir_write  = ir_write_s  & rst_n;
   assign pc_update = pc_update_s & rst_n;
   assign reg_write = reg_write_s & rst_n;
   assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: one record per clock cycle,
// plus hand-written sequences for the illegal-opcode and mid-instruction reset cases.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_write, adr_src, ir_write, pc_update, reg_write, halt;
   logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, alu_op;
   logic [31:0] instret;

   int tests_run = 0;
   int tests_failed = 0;

   multicycle_controller #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_update(pc_update), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .imm_src(imm_src), .alu_op(alu_op), .halt(halt), .instret(instret)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IA  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] ILL = 7'b1110011;

   // {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write, a, b, result_src, alu_op, halt}
   localparam logic [14:0] C_FETCH1 = 15'b100110_00_10_10_00_0;
   localparam logic [14:0] C_FETCH0 = 15'b100000_00_10_10_00_0;
   localparam logic [14:0] C_RST    = 15'b000000_00_10_10_00_0;
   localparam logic [14:0] C_DEC    = 15'b000000_01_01_00_00_0;
   localparam logic [14:0] C_MADR   = 15'b000000_10_01_00_00_0;
   localparam logic [14:0] C_MRD    = 15'b101000_00_00_00_00_0;
   localparam logic [14:0] C_MWB    = 15'b000001_00_00_01_00_0;
   localparam logic [14:0] C_MWR    = 15'b111000_00_00_00_00_0;
   localparam logic [14:0] C_EXR    = 15'b000000_10_00_00_10_0;
   localparam logic [14:0] C_EXI    = 15'b000000_10_01_00_10_0;
   localparam logic [14:0] C_JAL    = 15'b000010_01_10_00_00_0;
   localparam logic [14:0] C_AWB    = 15'b000001_00_00_00_00_0;
   localparam logic [14:0] C_BR1    = 15'b000010_10_00_00_01_0;
   localparam logic [14:0] C_BR0    = 15'b000000_10_00_00_01_0;
   localparam logic [14:0] C_ILL    = 15'b000000_00_00_00_00_1;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        zero;
      logic        rdy;
      logic [14:0] ctl;
      logic [1:0]  imm;
      logic [31:0] inst;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [6:0] o, logic [2:0] f, logic z, logic r,
                               logic [14:0] c, logic [1:0] im, int n);
      vec_t v;
      v.op = o; v.f3 = f; v.zero = z; v.rdy = r; v.ctl = c; v.imm = im; v.inst = n;
      return v;
   endfunction

   function automatic logic [14:0] ctl_now();
      return {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
              alu_src_a, alu_src_b, result_src, alu_op, halt};
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [14:0] c, input logic [1:0] im, input logic [31:0] n);
      check("ctl", idx, {17'd0, ctl_now()}, {17'd0, c});
      check("imm_src", idx, {30'd0, imm_src}, {30'd0, im});
      check("instret", idx, instret, n);
   endtask

   // Apply one record, compare before the next rising edge, then advance one cycle
   task automatic step(input vec_t v, input int idx);
      op = v.op; funct3 = v.f3; zero = v.zero; mem_ready = v.rdy;
      #1;
      check_all(idx, v.ctl, v.imm, v.inst);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // add, addi, beq/bne both ways, sw, jal, lw with stalls, sw with stall, add, then illegal
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b00, 0));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_DEC,    2'b00, 0));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_EXR,    2'b00, 0));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_AWB,    2'b00, 0));
      tbl.push_back(mk(IA, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b00, 1));
      tbl.push_back(mk(IA, 3'd0, 1'b0, 1'b1, C_DEC,    2'b00, 1));
      tbl.push_back(mk(IA, 3'd0, 1'b0, 1'b1, C_EXI,    2'b00, 1));
      tbl.push_back(mk(IA, 3'd0, 1'b0, 1'b1, C_AWB,    2'b00, 1));
      tbl.push_back(mk(BR, 3'd0, 1'b1, 1'b1, C_FETCH1, 2'b10, 2));
      tbl.push_back(mk(BR, 3'd0, 1'b1, 1'b1, C_DEC,    2'b10, 2));
      tbl.push_back(mk(BR, 3'd0, 1'b1, 1'b1, C_BR1,    2'b10, 2));
      tbl.push_back(mk(BR, 3'd1, 1'b1, 1'b1, C_FETCH1, 2'b10, 3));
      tbl.push_back(mk(BR, 3'd1, 1'b1, 1'b1, C_DEC,    2'b10, 3));
      tbl.push_back(mk(BR, 3'd1, 1'b1, 1'b1, C_BR0,    2'b10, 3));
      tbl.push_back(mk(BR, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b10, 4));
      tbl.push_back(mk(BR, 3'd0, 1'b0, 1'b1, C_DEC,    2'b10, 4));
      tbl.push_back(mk(BR, 3'd0, 1'b0, 1'b1, C_BR0,    2'b10, 4));
      tbl.push_back(mk(BR, 3'd1, 1'b0, 1'b1, C_FETCH1, 2'b10, 5));
      tbl.push_back(mk(BR, 3'd1, 1'b0, 1'b1, C_DEC,    2'b10, 5));
      tbl.push_back(mk(BR, 3'd1, 1'b0, 1'b1, C_BR1,    2'b10, 5));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_FETCH1, 2'b01, 6));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_DEC,    2'b01, 6));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_MADR,   2'b01, 6));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_MWR,    2'b01, 6));
      tbl.push_back(mk(JL, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b11, 7));
      tbl.push_back(mk(JL, 3'd0, 1'b0, 1'b1, C_DEC,    2'b11, 7));
      tbl.push_back(mk(JL, 3'd0, 1'b0, 1'b1, C_JAL,    2'b11, 7));
      tbl.push_back(mk(JL, 3'd0, 1'b0, 1'b1, C_AWB,    2'b11, 7));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b0, C_FETCH0, 2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b1, C_FETCH1, 2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b1, C_DEC,    2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b1, C_MADR,   2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b0, C_MRD,    2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b0, C_MRD,    2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b1, C_MRD,    2'b00, 8));
      tbl.push_back(mk(LW, 3'd2, 1'b0, 1'b1, C_MWB,    2'b00, 8));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_FETCH1, 2'b01, 9));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_DEC,    2'b01, 9));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b0, C_MADR,   2'b01, 9));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b0, C_MWR,    2'b01, 9));
      tbl.push_back(mk(SW, 3'd2, 1'b0, 1'b1, C_MWR,    2'b01, 9));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b00, 10));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_DEC,    2'b00, 10));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_EXR,    2'b00, 10));
      tbl.push_back(mk(RT, 3'd0, 1'b0, 1'b1, C_AWB,    2'b00, 10));
      tbl.push_back(mk(ILL, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b00, 11));
      tbl.push_back(mk(ILL, 3'd0, 1'b0, 1'b1, C_DEC,    2'b00, 11));

      // Reset state: enables forced low even with mem_ready high in FETCH
      rst_n = 1'b0; op = RT; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
      #2;
      check_all(900, C_RST, 2'b00, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i], i);

      // Illegal opcode is absorbing: halt held, counter frozen for 20 cycles
      for (int k = 0; k < 20; k++)
         step(mk(ILL, 3'd0, k[0], ~k[0], C_ILL, 2'b00, 11), 100 + k);

      // Reset out of ILLEGAL, retire one add, then reset in the middle of a lw
      rst_n = 1'b0;
      #1;
      check_all(901, C_RST, 2'b00, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(RT, 3'd0, 1'b0, 1'b1, C_FETCH1, 2'b00, 0), 200);
      step(mk(RT, 3'd0, 1'b0, 1'b1, C_DEC,    2'b00, 0), 201);
      step(mk(RT, 3'd0, 1'b0, 1'b1, C_EXR,    2'b00, 0), 202);
      step(mk(RT, 3'd0, 1'b0, 1'b1, C_AWB,    2'b00, 0), 203);
      step(mk(LW, 3'd2, 1'b0, 1'b1, C_FETCH1, 2'b00, 1), 204);
      step(mk(LW, 3'd2, 1'b0, 1'b1, C_DEC,    2'b00, 1), 205);
      step(mk(LW, 3'd2, 1'b0, 1'b1, C_MADR,   2'b00, 1), 206);
      mem_ready = 1'b0;
      #1;
      check_all(207, C_MRD, 2'b00, 32'd1);
      #1;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_all(208, C_RST, 2'b00, 32'd0);
      #1;
      rst_n = 1'b1;

      // Branch with an unsupported funct3 is illegal
      step(mk(BR, 3'd2, 1'b0, 1'b1, C_FETCH1, 2'b10, 0), 209);
      step(mk(BR, 3'd2, 1'b0, 1'b1, C_DEC,    2'b10, 0), 210);
      step(mk(BR, 3'd2, 1'b0, 1'b1, C_ILL,    2'b10, 0), 211);
      step(mk(BR, 3'd2, 1'b0, 1'b1, C_ILL,    2'b10, 0), 212);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style main control FSM that sequences the shared datapath (ALU, register file, unified instruction/data memory port) of the multicycle RV32I core variant.
- Each instruction is walked through fetch/decode/execute/memory/writeback states.
- In each state the FSM drives the mux selects, write enables and the 2-bit ALU-op class.
- The existing ALU decoder consumes alu_op, funct3 and funct7b5 to produce the 3-bit ALU control.
- The FSM also waits on the memory ready handshake, counts retired instructions and halts on unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
op  in  7  opcode field from instruction register; valid from DECODE onward.
funct3  in  3  instruction funct3 from instruction register.
zero  in  1  ALU zero flag, combinational from current ALU inputs.
mem_ready  in  1  memory accepted/completed the current access this cycle.
mem_req  out  1  memory access request.
mem_write  out  1  memory write strobe; qualified by mem_req.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  load instruction register and OldPC.
pc_update  out  1  PC write enable.
reg_write  out  1  register-file write enable.
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
alu_src_b  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
result_src  out  2  result bus select: 00 = ALUOut, 01 = read data, 10 = ALU result.
imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from op.
alu_op  out  2  ALU class to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
halt  out  1  core stopped on illegal instruction.
instret  out  CNT_W  retired instruction count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FETCH, instret = 0, halt = 0.
  - While rst_n is low, mem_req, mem_write, ir_write, pc_update and reg_write are forced to 0; selects show their FETCH values.
  - On deassertion, FETCH begins on the next rising edge.
  - Reset mid-instruction abandons the instruction; the counter does not increment.
- Outputs are functions of state only, except pc_update in BRANCH, and ir_write/pc_update in FETCH, which are gated by mem_ready. Unlisted outputs are 0.
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 branch (funct3 000 beq, 001 bne), 1101111 jal. Anything else is illegal; a branch with any other funct3 is also illegal.
- States:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state: lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; branch -> BRANCH; jal -> JAL; else -> ILLEGAL.
  - MEMADR: a=10, b=01, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Stay while !mem_ready, else go to MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Stay while !mem_ready, else go to FETCH.
  - EXECUTER: a=10, b=00, alu_op=10 -> ALUWB.
  - EXECUTEI: a=10, b=01, alu_op=10 -> ALUWB.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00; pc_update = zero XOR funct3[0]. Next state FETCH.
  - ILLEGAL: halt=1, all enables 0, mem_req=0; absorbing until reset.
- instret increments by 1 (wraps at 2^CNT_W) on each edge that leaves MEMWB, ALUWB or BRANCH, and on the edge leaving MEMWRITE with mem_ready=1. It never increments in ILLEGAL.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Cycle counts with mem_ready=1:
  - lw: 5.
  - sw: 4.
  - R/I/jal: 4.
  - branch: 3.
  - Each low-mem_ready cycle in a memory state adds 1.

Test Plan:
- Reset, then add (op 0110011), mem_ready=1 -> FETCH, DECODE, EXECUTER (alu_op=10, a=10, b=00), ALUWB (reg_write=1 one cycle, result_src=00); instret 0->1 on the 4th edge.
- lw with mem_ready low 2 cycles in MEMREAD -> 7 cycles total; mem_req=1 and adr_src=1 held for 3 cycles; reg_write=1 only in MEMWB with result_src=01.
- beq with zero=1 -> pc_update=1 in BRANCH; bne with zero=1 -> pc_update=0; both return to FETCH after 3 cycles, instret +1 each.
- sw, mem_ready=1 -> mem_write=1 for exactly one cycle, reg_write never asserted, instret +1 when leaving MEMWRITE.
- jal -> pc_update=1 in JAL with a=01, b=10; reg_write=1 next cycle; 4 cycles total.
- op 1110011 -> ILLEGAL after DECODE: halt=1, no enables, instret frozen for 20 cycles. Separately, rst_n low mid-MEMREAD -> enables drop immediately, state FETCH, instret=0, halt=0.
